// File: rtl/div_pkg.sv
// Shared types for the divider issue sequencer and the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    // Accept-to-response latency of the divider path, for benches.
    localparam int DIV_LATENCY = 36;

    function automatic logic is_signed_op(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/div_issue_special.sv
// RISC-V divide special cases: divide-by-zero and signed overflow.
module div_special
    import div_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  div_op_t              op,
    input  logic [D_WIDTH-1:0]   a,
    input  logic [D_WIDTH-1:0]   b,
    output logic                 is_special,
    output logic [D_WIDTH-1:0]   special_result
);

    localparam logic [D_WIDTH-1:0] ALL_ONES = {D_WIDTH{1'b1}};
    localparam logic [D_WIDTH-1:0] MIN_NEG  = {1'b1, {D_WIDTH-1{1'b0}}};

    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        if (b == '0) begin
            is_special     = 1'b1;
            special_result = ((op == DIV) || (op == DIVU)) ? ALL_ONES : a;
        end else if (is_signed_op(op) && (a == MIN_NEG) && (b == ALL_ONES)) begin
            is_special     = 1'b1;
            special_result = (op == DIV) ? a : '0;
        end
    end

endmodule

// File: rtl/div_issue.sv
// Sequencer between execute and the 32-step divider: fast special cases,
// single-pulse divider start, flush-as-kill since the divider cannot abort.
module div_issue
    import div_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int TAG_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  div_op_t             req_op,
    input  logic [D_WIDTH-1:0]  req_a,
    input  logic [D_WIDTH-1:0]  req_b,
    input  logic [TAG_W-1:0]    req_tag,
    input  logic                flush,
    output logic                resp_valid,
    output logic [D_WIDTH-1:0]  resp_result,
    output logic [TAG_W-1:0]    resp_tag,
    output logic                busy,
    output logic                div_start,
    output div_op_t             div_ctrl,
    output logic [D_WIDTH-1:0]  div_num,
    output logic [D_WIDTH-1:0]  div_den,
    input  logic [D_WIDTH-1:0]  div_result,
    input  logic                div_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FAST  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 killed_q;
    div_op_t              op_q;
    logic [D_WIDTH-1:0]   a_q, b_q, spec_q, res_hold_q;
    logic [TAG_W-1:0]     tag_q, tag_hold_q;
    logic                 accept, is_special;
    logic [D_WIDTH-1:0]   special_result;

    div_special #(.D_WIDTH(D_WIDTH)) u_special (
        .op             (req_op),
        .a              (req_a),
        .b              (req_b),
        .is_special     (is_special),
        .special_result (special_result)
    );

    assign req_ready = (state_q == IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != IDLE);
    assign div_ctrl  = op_q;
    assign div_num   = a_q;
    assign div_den   = b_q;

    always_comb begin
        state_d    = state_q;
        resp_valid = 1'b0;
        div_start  = 1'b0;
        unique case (state_q)
            IDLE:  if (accept) state_d = is_special ? FAST : ISSUE;
            FAST: begin
                resp_valid = !(killed_q || flush);
                state_d    = IDLE;
            end
            ISSUE: begin
                div_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT:  if (!div_busy) state_d = RESP;
            RESP: begin
                resp_valid = !(killed_q || flush);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs hold the last delivered response while resp_valid is low.
    assign resp_result = resp_valid ? ((state_q == RESP) ? div_result : spec_q) : res_hold_q;
    assign resp_tag    = resp_valid ? tag_q : tag_hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            killed_q   <= 1'b0;
            op_q       <= DIV;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            spec_q     <= '0;
            res_hold_q <= '0;
            tag_hold_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= req_op;
                a_q    <= req_a;
                b_q    <= req_b;
                tag_q  <= req_tag;
                spec_q <= special_result;
            end
            if ((state_q == IDLE) || (state_d == IDLE))
                killed_q <= 1'b0;
            else if (flush)
                killed_q <= 1'b1;
            if (resp_valid) begin
                res_hold_q <= resp_result;
                tag_hold_q <= resp_tag;
            end
        end
    end

endmodule

// File: doc/div_issue.md
Name: div_issue

Overview:
- Sequencer between the execute stage and the iterative 32-step divider. It accepts one DIV/DIVU/REM/REMU request at a time.
- Requests for RISC-V special cases (divide-by-zero, signed overflow) complete in one cycle without using the divider.
- All other requests are registered, the divider is started with a single-cycle pulse, operands are held stable, and the divider result is returned with its destination tag.
- A flushed request is discarded once the divider finishes, because the divider cannot be aborted.

Parameters:
- D_WIDTH, 32, operand/result width
- TAG_W, 5, destination register tag width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  2  div_op_t: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a  in  D_WIDTH  dividend
- req_b  in  D_WIDTH  divisor
- req_tag  in  TAG_W  destination tag
- flush  in  1  kill the in-flight or presented request
- resp_valid  out  1  one-cycle result pulse
- resp_result  out  D_WIDTH  result
- resp_tag  out  TAG_W  tag of the result
- busy  out  1  high whenever the state is not IDLE (pipeline stall)
- div_start  out  1  divider start, one-cycle pulse
- div_ctrl  out  2  op to divider
- div_num  out  D_WIDTH  dividend to divider
- div_den  out  D_WIDTH  divisor to divider
- div_result  in  D_WIDTH  divider result, registered in the divider's DONE cycle
- div_busy  in  1  divider busy

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values: state=IDLE, killed=0, and the registered op/a/b/tag are cleared to 0. Outputs follow: req_ready=1, resp_valid=0, busy=0, div_start=0.
- Reset mid-operation returns to IDLE immediately. The divider shares `rst`, so both blocks restart together.
- States: IDLE, FAST, ISSUE, WAIT, RESP.
- Handshake: req_ready = (state==IDLE) & ~flush. A request is accepted when req_valid & req_ready. Op, a, b and tag are registered on acceptance.
- Special-case detection on accept (combinational on the req_* inputs):
  - b==0: DIV/DIVU result all-ones; REM/REMU result = a.
  - Signed op with a==0x8000_0000 and b==all-ones: DIV result = a; REM result = 0.
  - On a special case the precomputed result is registered and the next state is FAST. Otherwise the next state is ISSUE.
- FAST (1 cycle): resp_valid=1 unless killed, then go to IDLE.
- ISSUE (1 cycle): div_start=1, then go to WAIT.
  - div_ctrl, div_num and div_den are driven from the registered copies in every state, so they stay stable through the divider's INIT cycle.
  - div_start is never high in two consecutive cycles, and is never asserted outside ISSUE.
- WAIT: while div_busy=1, stay. On div_busy=0, go to RESP.
  - The first WAIT cycle coincides with the divider's INIT, where div_busy=1.
  - div_busy=0 in WAIT marks the divider's DONE cycle; div_result is valid the following cycle.
- RESP (1 cycle): resp_valid = ~killed, resp_result=div_result, resp_tag = registered tag. Then go to IDLE and clear killed.
- Latency, acceptance at cycle T:
  - Fast path: resp_valid at T+1.
  - Divider path: ISSUE at T+1, divider INIT at T+2, DIVIDE T+3..T+34, DONE T+35, resp_valid at T+36. Total 36 cycles.
- flush:
  - In IDLE: blocks acceptance (flush wins over req_valid).
  - In FAST, ISSUE, WAIT or RESP: sets killed, suppresses resp_valid, and does not shorten the sequence.
  - A new request is accepted only after return to IDLE.
- resp_result and resp_tag hold their last value when resp_valid=0.
- Width rule: D_WIDTH is the only data width. Negative constants are formed by replicating all-ones; the overflow dividend is {1'b1, {D_WIDTH-1{1'b0}}}.

Decomposition:
- Shared package div_pkg: div_op_t enum (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11), reused by the divider's div_ctrl; the DIV_LATENCY=36 constant for benches.
- The state enum stays local.
- One combinational sub-module, div_special: inputs op, a, b; outputs is_special and special_result.

Test Plan:
- DIVU a=100, b=7 -> resp_valid exactly 36 cycles after accept, result 14; div_start high for exactly one cycle.
- REM a=-7 (0xFFFF_FFF9), b=2 -> result 0xFFFF_FFFF; resp_tag equals the accepted tag (e.g. 5'd9).
- DIV b=0, a=42 -> resp_valid at T+1, result 0xFFFF_FFFF, div_start never asserted. REMU b=0, a=42 -> 42.
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> T+1 result 0x8000_0000; REM with the same operands -> 0.
- DIV a=50, b=5 with flush at T+10 -> no resp_valid; busy stays high through T+36; req_ready returns at T+37; a follow-up DIVU 9/3 then returns 3 after 36 cycles.
- rst asserted at T+20 of a divide -> outputs at reset values the same cycle; a next request completes normally with the correct result.
